// File: rtl/stall_ctrl_pkg.sv
// Shared pipeline package for the stall controller.
// Contents:
//   stall_state_e    - controller FSM states (RUN, MEM_WAIT)
//   MAX_WAIT_DEFAULT - default consecutive MEM_WAIT cycles before an SRAM timeout
//   CNT_W_DEFAULT    - default width of the performance counters
//   wait_cnt_width() - bits needed for a wait counter that counts 0 .. max_wait-1
package stall_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } stall_state_e;

    localparam int unsigned MAX_WAIT_DEFAULT = 15;
    localparam int unsigned CNT_W_DEFAULT    = 16;

    // The wait counter never holds MAX_WAIT itself: the timeout fires while it
    // still reads MAX_WAIT-1, so $clog2(max_wait) bits are enough.
    function automatic int unsigned wait_cnt_width(input int unsigned max_wait);
        return (max_wait <= 2) ? 1 : $clog2(max_wait);
    endfunction

endpackage

// File: rtl/stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall controller performance counters.
// Ports:
//   clk   - clock, rising edge
//   clear - synchronous clear, has priority over inc
//   inc   - add one this cycle, unless already at the all-ones maximum
//   count - current count value
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller.
// Arbitrates memory stalls, taken-branch flushes and data-hazard stalls, and
// keeps sticky SRAM-timeout status plus two saturating performance counters.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   hazard            - data-hazard request from ID
//   branch_taken_EXE  - branch resolved taken in EXE
//   mem_req_MEM       - MEM stage needs SRAM this cycle
//   sram_ready        - SRAM access complete
//   freeze_PC         - hold PC
//   freeze_IF_ID      - hold IF/ID
//   flush_IF_ID       - clear IF/ID to NOP
//   bubble_ID_EXE     - load NOP into ID/EXE
//   freeze_all        - hold ID/EXE, EXE/MEM, MEM/WB
//   timeout_err       - sticky SRAM timeout flag
//   stall_cycles      - saturating count of cycles with freeze_PC or freeze_all
//   flush_count       - saturating count of cycles with flush_IF_ID
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken_EXE,
    input  logic             mem_req_MEM,
    input  logic             sram_ready,
    output logic             freeze_PC,
    output logic             freeze_IF_ID,
    output logic             flush_IF_ID,
    output logic             bubble_ID_EXE,
    output logic             freeze_all,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned     WAIT_W    = wait_cnt_width(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    stall_state_e      state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              timeout_q;
    logic              mem_stall;

    // Control outputs: memory stall first, then branch flush, then hazard stall.
    always_comb begin
        mem_stall = 1'b0;
        case (state_q)
            RUN:      mem_stall = mem_req_MEM && !sram_ready;
            MEM_WAIT: mem_stall = !sram_ready;
            default:  mem_stall = 1'b0;
        endcase

        freeze_all    = mem_stall;
        freeze_PC     = mem_stall || (!branch_taken_EXE && hazard);
        freeze_IF_ID  = mem_stall || (!branch_taken_EXE && hazard);
        flush_IF_ID   = !mem_stall && branch_taken_EXE;
        bubble_ID_EXE = !mem_stall && (branch_taken_EXE || hazard);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    wait_cnt_q <= '0;
                    if (mem_req_MEM && !sram_ready) begin
                        state_q <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (sram_ready) begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        // MAX_WAIT-th consecutive wait cycle without ready: give up.
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                        timeout_q  <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                default: begin
                    state_q    <= RUN;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

    assign timeout_err = timeout_q;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (freeze_PC || freeze_all),
        .count (stall_cycles)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (flush_IF_ID),
        .count (flush_count)
    );

endmodule

// File: tb/tb_stall_ctrl.sv
module tb_stall_ctrl;

    localparam int unsigned MAX_WAIT = 15;
    localparam int unsigned CNT_W    = 4;
    localparam int          SAT      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, hazard, branch_taken_EXE, mem_req_MEM, sram_ready;
    logic             freeze_PC, freeze_IF_ID, flush_IF_ID, bubble_ID_EXE, freeze_all;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    stall_ctrl #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .hazard           (hazard),
        .branch_taken_EXE (branch_taken_EXE),
        .mem_req_MEM      (mem_req_MEM),
        .sram_ready       (sram_ready),
        .freeze_PC        (freeze_PC),
        .freeze_IF_ID     (freeze_IF_ID),
        .flush_IF_ID      (flush_IF_ID),
        .bubble_ID_EXE    (bubble_ID_EXE),
        .freeze_all       (freeze_all),
        .timeout_err      (timeout_err),
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
    );

    always #5 clk = ~clk;

    // Control bundle order: {freeze_PC, freeze_IF_ID, flush_IF_ID, bubble_ID_EXE, freeze_all}
    localparam logic [4:0] C_IDLE   = 5'b00000;
    localparam logic [4:0] C_MEM    = 5'b11001;
    localparam logic [4:0] C_BRANCH = 5'b00110;
    localparam logic [4:0] C_HAZARD = 5'b11010;

    logic [4:0]           ctl;
    logic [5+1+2*CNT_W-1:0] obs_vec;
    assign ctl     = {freeze_PC, freeze_IF_ID, flush_IF_ID, bubble_ID_EXE, freeze_all};
    assign obs_vec = {ctl, timeout_err, stall_cycles, flush_count};

    int checks = 0;
    int errors = 0;

    // Reference model: is the controller waiting on SRAM, how many waits so far,
    // sticky error, and the two event counts as plain integers.
    bit   m_waiting = 1'b0;
    int   m_waits   = 0;
    bit   m_err     = 1'b0;
    int   m_stall   = 0;
    int   m_flush   = 0;
    logic [4:0]             exp_ctl;
    logic [5+1+2*CNT_W-1:0] exp_vec;

    // Apply inputs, predict outputs, move to the falling edge for sampling.
    task automatic drive(input logic h, input logic b, input logic m, input logic r,
                         input logic rs);
        bit stalled;
        hazard = h; branch_taken_EXE = b; mem_req_MEM = m; sram_ready = r; rst = rs;
        stalled = m_waiting ? !r : (m && !r);
        if (stalled)   exp_ctl = C_MEM;
        else if (b)    exp_ctl = C_BRANCH;
        else if (h)    exp_ctl = C_HAZARD;
        else           exp_ctl = C_IDLE;
        exp_vec = {exp_ctl, m_err, CNT_W'(m_stall), CNT_W'(m_flush)};
        #4;
    endtask

    // Take the rising edge and advance the model with the inputs seen there.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_waiting = 1'b0; m_waits = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (exp_ctl[4] || exp_ctl[0]) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
            if (exp_ctl[2])               m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
            if (m_waiting) begin
                if (sram_ready) begin
                    m_waiting = 1'b0; m_waits = 0;
                end else begin
                    m_waits++;
                    if (m_waits >= MAX_WAIT) begin
                        m_err = 1'b1; m_waiting = 1'b0; m_waits = 0;
                    end
                end
            end else begin
                m_waiting = mem_req_MEM && !sram_ready;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (obs_vec !== {C_IDLE, 1'b0, CNT_W'(0), CNT_W'(0)}) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs_vec,
                     {C_IDLE, 1'b0, CNT_W'(0), CNT_W'(0)});
        end
        tick();
    endtask

    task automatic test_hazard();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 0);
            checks++;
            if (ctl !== C_HAZARD || obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL hazard_cycle%0d: got %h want %h", i, obs_vec, exp_vec);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (stall_cycles !== CNT_W'(2) || ctl !== C_IDLE) begin
            errors++;
            $display("FAIL hazard_count: got stall=%0d ctl=%b want 2 %b",
                     stall_cycles, ctl, C_IDLE);
        end
        tick();
    endtask

    task automatic test_branch_priority();
        do_reset();
        drive(1, 1, 0, 0, 0);
        checks++;
        if (ctl !== C_BRANCH || obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL branch_over_hazard: got %h want %h", obs_vec, exp_vec);
        end
        tick();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (flush_count !== CNT_W'(1) || stall_cycles !== CNT_W'(0)) begin
            errors++;
            $display("FAIL branch_count: got flush=%0d stall=%0d want 1 0",
                     flush_count, stall_cycles);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0);
            checks++;
            if (ctl !== C_MEM || obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL mem_stall_cycle%0d: got %h want %h", i, obs_vec, exp_vec);
            end
            tick();
        end
        drive(0, 0, 1, 1, 0);
        checks++;
        if (ctl !== C_IDLE || obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL mem_release: got %h want %h", obs_vec, exp_vec);
        end
        tick();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (ctl !== C_IDLE || stall_cycles !== CNT_W'(3)) begin
            errors++;
            $display("FAIL mem_after: got ctl=%b stall=%0d want %b 3", ctl, stall_cycles, C_IDLE);
        end
        tick();
    endtask

    task automatic test_mem_branch();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 0, 0);
            checks++;
            if (ctl !== C_MEM || obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL mem_blocks_branch%0d: got %h want %h", i, obs_vec, exp_vec);
            end
            tick();
        end
        drive(0, 1, 1, 1, 0);
        checks++;
        if (ctl !== C_BRANCH || obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL branch_on_release: got %h want %h", obs_vec, exp_vec);
        end
        tick();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (flush_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL mem_branch_flush: got %0d want 1", flush_count);
        end
        tick();
    endtask

    // One RUN stall cycle plus MAX_WAIT MEM_WAIT cycles, then the timeout lands.
    task automatic test_timeout();
        do_reset();
        for (int i = 0; i <= MAX_WAIT; i++) begin
            drive(0, 0, 1, 0, 0);
            checks++;
            if (ctl !== C_MEM || timeout_err !== 1'b0 || obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL timeout_wait%0d: got %h want %h", i, obs_vec, exp_vec);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (ctl !== C_IDLE || timeout_err !== 1'b1 || obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL timeout_sticky%0d: got %h want %h", i, obs_vec, exp_vec);
            end
            tick();
        end
    endtask

    // Runs right after the timeout test so the sticky flag is still set.
    task automatic test_reset_mid_wait();
        drive(0, 0, 1, 0, 0);
        tick();
        drive(1, 1, 1, 0, 0);
        tick();
        drive(1, 1, 1, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (obs_vec !== {C_IDLE, 1'b0, CNT_W'(0), CNT_W'(0)}) begin
            errors++;
            $display("FAIL reset_mid_wait: got %h want %h", obs_vec,
                     {C_IDLE, 1'b0, CNT_W'(0), CNT_W'(0)});
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (stall_cycles !== CNT_W'(SAT) || obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL stall_saturate: got stall=%0d want %0d", stall_cycles, SAT);
        end
        tick();
    endtask

    task automatic test_random();
        int unsigned p_ready;
        logic        h, b, m, r, rs;
        do_reset();
        p_ready = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 400 == 0) p_ready = $urandom_range(2, 70);
            h  = ($urandom_range(0, 99) < 40);
            b  = ($urandom_range(0, 99) < 20);
            m  = ($urandom_range(0, 99) < 50);
            r  = ($urandom_range(0, 99) < p_ready);
            rs = ($urandom_range(0, 299) == 0);
            drive(h, b, m, r, rs);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h want %h", i, obs_vec, exp_vec);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; hazard = 1'b0; branch_taken_EXE = 1'b0;
        mem_req_MEM = 1'b0; sram_ready = 1'b0;
        exp_ctl = C_IDLE;
        exp_vec = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_hazard();
        test_branch_priority();
        test_mem_wait();
        test_mem_branch();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15, max consecutive MEM_WAIT cycles before timeout.
REQ-002 Parameter CNT_W, default 16, width of performance counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 hazard  input  1  data-hazard request from the hazard detection unit (ID stage).
REQ-006 branch_taken_EXE  input  1  branch resolved taken in EXE.
REQ-007 mem_req_MEM  input  1  load/store in MEM requires SRAM access this cycle.
REQ-008 sram_ready  input  1  SRAM access complete.
REQ-009 freeze_PC  output  1  hold PC register.
REQ-010 freeze_IF_ID  output  1  hold IF/ID pipeline register.
REQ-011 flush_IF_ID  output  1  clear IF/ID register to NOP.
REQ-012 bubble_ID_EXE  output  1  load NOP into ID/EXE register.
REQ-013 freeze_all  output  1  hold ID/EXE, EXE/MEM, MEM/WB registers.
REQ-014 timeout_err  output  1  sticky SRAM-timeout flag.
REQ-015 stall_cycles  output  CNT_W  saturating count of cycles with freeze_PC or freeze_all high.
REQ-016 flush_count  output  CNT_W  saturating count of cycles with flush_IF_ID high.

Function
REQ-017 FSM states SHALL be RUN and MEM_WAIT; control outputs are combinational from state and inputs, counters/flags registered.
REQ-018 RUN, mem_req_MEM=1, sram_ready=0: freeze_all=1, freeze_PC=1, freeze_IF_ID=1, flush/bubble=0; next state MEM_WAIT.
REQ-019 RUN, mem_req_MEM=1, sram_ready=1: no memory stall; state stays RUN.
REQ-020 MEM_WAIT, sram_ready=0: all freezes held at 1; wait counter increments.
REQ-021 MEM_WAIT, sram_ready=1: freezes deasserted that cycle; next state RUN; wait counter cleared.
REQ-022 Memory stall SHALL have priority: while freeze_all=1, flush_IF_ID=0 and bubble_ID_EXE=0 regardless of branch_taken_EXE or hazard.
REQ-023 No memory stall, branch_taken_EXE=1: flush_IF_ID=1, bubble_ID_EXE=1, freeze_PC=0, freeze_IF_ID=0 (hazard ignored).
REQ-024 No memory stall, no branch, hazard=1: freeze_PC=1, freeze_IF_ID=1, bubble_ID_EXE=1, flush_IF_ID=0.
REQ-025 No request active: all control outputs 0.
REQ-026 Wait counter reaching MAX_WAIT in MEM_WAIT with sram_ready=0: timeout_err set to 1 next edge, state forced to RUN, counter cleared; timeout_err remains 1 until rst.
REQ-027 Counters increment by 1 on qualifying cycles and SHALL hold at 2^CNT_W-1 (no wrap).

Reset
REQ-028 rst=1 at a clock edge: state RUN, wait counter 0, timeout_err 0, stall_cycles 0, flush_count 0.
REQ-029 rst SHALL override every other input, including mid-MEM_WAIT; combinational outputs evaluate as RUN from the following cycle.

Structure
REQ-030 State enum (RUN, MEM_WAIT) and MAX_WAIT default SHALL live in the shared ARM pipeline package.
REQ-031 One sub-module sat_counter (parameterised width, inc, clear, saturating) SHALL be instantiated twice for stall_cycles and flush_count.

Verification
REQ-032 hazard=1 for 2 cycles, others 0 -> freeze_PC=freeze_IF_ID=bubble_ID_EXE=1 both cycles, stall_cycles=2.
REQ-033 hazard=1 and branch_taken_EXE=1 same cycle -> flush_IF_ID=1, bubble_ID_EXE=1, freeze_PC=0, flush_count=1.
REQ-034 mem_req_MEM=1, sram_ready low 3 cycles then high -> freeze_all=1 for 3 cycles, 0 on ready cycle, state RUN after, stall_cycles=3.
REQ-035 mem_req_MEM=1 with branch_taken_EXE=1, sram_ready=0 -> freeze_all=1, flush_IF_ID=0; branch flush taken only in the cycle sram_ready=1 releases the stall.
REQ-036 mem_req_MEM=1, sram_ready held 0 with MAX_WAIT=15 -> timeout_err=1 after the 15th wait cycle, state RUN, flag persists until rst.
REQ-037 CNT_W=4, hazard held 20 cycles -> stall_cycles saturates at 15; rst asserted mid-MEM_WAIT -> all counters 0, timeout_err 0, outputs 0 next cycle.
